clk_gen_tune_ctrl: RTL and testbench

CLK_GEN_TUNE_CTRL -- requirements
Module: clk_gen_tune_ctrl

---
 rtl/clk_gen_tune_pkg.sv | 40 ++++
 rtl/clk_gen_edge_counter.sv | 49 ++++
 rtl/clk_gen_tune_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clk_gen_tune_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_tune_pkg.sv
// rtl/clk_gen_tune_pkg.sv - shared types and constants for the oscillator tap tuning controller
//
// Purpose: state and direction enums, bus widths, and the signed count
// difference helper used by clk_gen_tune_ctrl and clk_gen_edge_counter.
// Ports: none (package).
package clk_gen_tune_pkg;

  localparam int SEL_W  = 4;
  localparam int CNT_W  = 13;
  localparam int DIFF_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SEL_W-1:0] SEL_MAX = '1;
  localparam logic [SEL_W-1:0] SEL_MIN = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    DIR_NULL,
    DIR_UP,
    DIR_DN
  } dir_t;

  // Both operands are unsigned 13-bit; widening by one zero bit keeps the
  // subtraction exact in 14-bit two's complement.
  function automatic logic signed [DIFF_W-1:0] count_diff(
    input logic [CNT_W-1:0] count,
    input logic [CNT_W-1:0] target
  );
    return $signed({1'b0, count}) - $signed({1'b0, target});
  endfunction

endpackage

// File: rtl/clk_gen_edge_counter.sv
// rtl/clk_gen_edge_counter.sv - synchronized rising-edge counter for the divided oscillator
//
// Purpose: brings osc_in into the clk domain through two flops, detects
// synchronized 0->1 transitions and counts them while enabled, saturating at
// the maximum 13-bit value.
// Ports:
//   clk     in   sole clock
//   reset   in   synchronous active-high reset
//   osc_in  in   divided oscillator, asynchronous to clk
//   clear   in   zero the count (wins over enable)
//   enable  in   count edges this cycle
//   count   out  edges counted since last clear
module clk_gen_edge_counter
  import clk_gen_tune_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             osc_in,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;
  logic rise;

  assign rise = sync_q2 & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
      count   <= '0;
    end else begin
      sync_q1 <= osc_in;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
      if (clear) begin
        count <= '0;
      end else if (enable && rise && (count != CNT_MAX)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_gen_tune_ctrl.sv
// rtl/clk_gen_tune_ctrl.sv - successive tap search locking a ring oscillator to a target edge count
//
// Purpose: after start, repeatedly settles, counts osc_in rising edges over a
// fixed window and steps the tap select one position toward the target until
// the count is within tol, the search reverses direction, or a tap limit is hit.
// Optional feature macro: CLK_GEN_TUNE_DBG_EN adds meas_count and iter outputs.
// Ports:
//   clk           in   sole clock
//   reset         in   synchronous active-high reset
//   start         in   one-cycle pulse starting a run (ignored while busy)
//   target_count  in   desired edges per window
//   tol           in   accepted |count - target_count|
//   osc_in        in   divided oscillator, asynchronous
//   sel           out  tap select for the 16:1 mux
//   busy          out  run in progress
//   locked        out  run ended in range
//   fail          out  run ended at a tap limit
//   meas_count    out  (debug) last completed window count
//   iter          out  (debug) COMPARE cycles in current run
module clk_gen_tune_ctrl
  import clk_gen_tune_pkg::*;
#(
  parameter int               WINDOW_CYCLES = 1024,
  parameter int               SETTLE_CYCLES = 16,
  parameter logic [SEL_W-1:0] INIT_SEL      = 4'd8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] target_count,
  input  logic [3:0]       tol,
  input  logic             osc_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             locked,
  output logic             fail
`ifdef CLK_GEN_TUNE_DBG_EN
  ,
  output logic [CNT_W-1:0] meas_count,
  output logic [4:0]       iter
`endif
);

  localparam int TMR_W = 13;
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);

  state_t             state, state_n;
  dir_t               last_dir, dir_n;
  logic [SEL_W-1:0]   sel_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               cnt_clear;
  logic               cnt_en;
  logic               run_start;
  logic [CNT_W-1:0]   count;
  logic signed [DIFF_W-1:0] d;
  logic signed [DIFF_W-1:0] tol_s;

  clk_gen_edge_counter u_edge_counter (
    .clk    (clk),
    .reset  (reset),
    .osc_in (osc_in),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sel      <= INIT_SEL;
      last_dir <= DIR_NULL;
      timer    <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      last_dir <= dir_n;
      timer    <= timer_n;
    end
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    dir_n     = last_dir;
    timer_n   = timer;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    run_start = 1'b0;
    d         = count_diff(count, target_count);
    tol_s     = $signed({{(DIFF_W-4){1'b0}}, tol});

    case (state)
      ST_IDLE, ST_LOCKED, ST_FAIL: begin
        if (start) begin
          run_start = 1'b1;
          state_n   = ST_SETTLE;
          sel_n     = INIT_SEL;
          dir_n     = DIR_NULL;
          timer_n   = '0;
          cnt_clear = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (timer == SET_LAST) begin
          timer_n   = '0;
          cnt_clear = 1'b1;
          state_n   = ST_MEASURE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      ST_MEASURE: begin
        cnt_en = 1'b1;
        if (timer == WIN_LAST) begin
          timer_n = '0;
          state_n = ST_COMPARE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      ST_COMPARE: begin
        if (d > tol_s) begin
          // Oscillator too fast: move to a slower tap.
          dir_n = DIR_UP;
          if (sel == SEL_MAX) begin
            state_n = ST_FAIL;
          end else begin
            sel_n   = sel + 1'b1;
            // A reversal means target lies between the last two taps.
            state_n = (last_dir == DIR_DN) ? ST_LOCKED : ST_SETTLE;
          end
        end else if (d < -tol_s) begin
          dir_n = DIR_DN;
          if (sel == SEL_MIN) begin
            state_n = ST_FAIL;
          end else begin
            sel_n   = sel - 1'b1;
            state_n = (last_dir == DIR_UP) ? ST_LOCKED : ST_SETTLE;
          end
        end else begin
          state_n = ST_LOCKED;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign busy   = (state == ST_SETTLE) || (state == ST_MEASURE) || (state == ST_COMPARE);
  assign locked = (state == ST_LOCKED);
  assign fail   = (state == ST_FAIL);

`ifdef CLK_GEN_TUNE_DBG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_count <= '0;
      iter       <= '0;
    end else if (run_start) begin
      meas_count <= '0;
      iter       <= '0;
    end else if (state == ST_COMPARE) begin
      meas_count <= count;
      iter       <= iter + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_gen_tune_ctrl.sv
// tb/tb_clk_gen_tune_ctrl.sv - directed scoreboard bench for clk_gen_tune_ctrl
module tb_clk_gen_tune_ctrl;
  import clk_gen_tune_pkg::*;

  localparam int WIN    = 512;
  localparam int SETTLE = 16;
  localparam int K_STEP = 0;
  localparam int K_LOCK = 1;
  localparam int K_FAIL = 2;

  typedef struct {
    int kind;
    int sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        osc_in = 1'b0;
  logic [12:0] target_count = '0;
  logic [3:0]  tol = '0;
  logic [3:0]  sel;
  logic        busy;
  logic        locked;
  logic        fail;
`ifdef CLK_GEN_TUNE_DBG_EN
  logic [12:0] meas_count;
  logic [4:0]  iter;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode = 0;
  int   ph = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  clk_gen_tune_ctrl #(
    .WINDOW_CYCLES (WIN),
    .SETTLE_CYCLES (SETTLE),
    .INIT_SEL      (4'd8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .target_count (target_count),
    .tol          (tol),
    .osc_in       (osc_in),
    .sel          (sel),
    .busy         (busy),
    .locked       (locked),
    .fail         (fail)
`ifdef CLK_GEN_TUNE_DBG_EN
    ,
    .meas_count   (meas_count),
    .iter         (iter)
`endif
  );

  // Oscillator model: edges per window as a function of sel.
  function automatic int model_count(input int m, input int s);
    int n;
    case (m)
      1:       n = 140 - 5 * s;
      2:       n = 100;
      3:       n = 120 - 10 * s;
      default: n = 0;
    endcase
    if (n < 0) n = 0;
    if (n > WIN / 4) n = WIN / 4;
    return n;
  endfunction

  // Pattern repeats every WIN cycles with N pulses, so any WIN-cycle window
  // taken while sel is stable contains exactly N rising edges.
  always @(negedge clk) begin
    ph <= (ph == WIN - 1) ? 0 : ph + 1;
    if (mode == 4) osc_in <= 1'b1;
    else osc_in <= ((ph % 4) < 2) && ((ph / 4) < model_count(mode, int'(sel)));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic predict(input int m, input int tgt, input int tl);
    int s;
    int last;
    int d;
    int dir;
    s = 8;
    last = 0;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      d = model_count(m, s) - tgt;
      if (d <= tl && d >= -tl) begin
        q.push_back('{K_LOCK, s});
        return;
      end
      dir = (d > tl) ? 1 : 2;
      if ((dir == 1 && s == 15) || (dir == 2 && s == 0)) begin
        q.push_back('{K_FAIL, s});
        return;
      end
      s = (dir == 1) ? s + 1 : s - 1;
      if (last != 0 && last != dir) begin
        q.push_back('{K_LOCK, s});
        return;
      end
      q.push_back('{K_STEP, s});
      last = dir;
    end
  endtask

  task automatic run(input int m, input int tgt, input int tl, input int poke_at, input string name);
    int   cyc;
    int   steps;
    int   prev;
    bit   done;
    exp_t e;
    mode = m;
    target_count = 13'(tgt);
    tol = 4'(tl);
    predict(m, tgt, tl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_sel_init"}, sel, 8);
    prev = int'(sel);
    done = 0;
    cyc = 0;
    steps = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke_at);
      if (locked || fail) begin
        done = 1;
        if (q.size() == 0) begin
          check({name, "_unexpected_end"}, 0, 1);
        end else begin
          e = q.pop_front();
          check({name, "_end_kind"}, locked ? K_LOCK : K_FAIL, e.kind);
          check({name, "_end_sel"}, sel, e.sel);
          check({name, "_end_busy"}, busy, 0);
`ifdef CLK_GEN_TUNE_DBG_EN
          check({name, "_dbg_iter"}, iter, steps + 1);
          check({name, "_dbg_meas"}, meas_count, model_count(m, prev));
`endif
        end
      end else if (int'(sel) != prev) begin
        if (q.size() == 0) begin
          check({name, "_unexpected_step"}, 0, 1);
          done = 1;
        end else begin
          e = q.pop_front();
          check({name, "_step_kind"}, K_STEP, e.kind);
          check({name, "_step_sel"}, sel, e.sel);
          steps++;
          prev = int'(sel);
        end
      end
    end
    start = 1'b0;
    if (!done) check({name, "_timeout"}, 0, 1);
    check({name, "_queue_drained"}, q.size(), 0);
    check({name, "_compare_bound"}, (steps + 1) <= 16, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_sel", sel, 8);
    check("reset_busy", busy, 0);
    check("reset_locked", locked, 0);
    check("reset_fail", fail, 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_sel", sel, 8);
    check("idle_busy", busy, 0);
    check("idle_locked", locked, 0);
    check("idle_fail", fail, 0);

    // Converging search with an ignored start pulse mid-run.
    run(1, 70, 3, 600, "m1");
    check("m1_locked_hold", locked, 1);

    // Always too fast: climbs to the top tap and fails.
    run(2, 50, 2, 0, "m2");
    check("m2_fail_flag", fail, 1);

    // Count crosses target between taps 5 and 6 with zero tolerance.
    run(3, 65, 0, 0, "m3");
    check("m3_locked_flag", locked, 1);

    // Reset in the second window's MEASURE phase, with start held during reset.
    mode = 1;
    target_count = 13'd70;
    tol = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (600) @(negedge clk);
    check("abort_pre_busy", busy, 1);
    check("abort_pre_sel", sel, 9);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_sel", sel, 8);
    check("abort_busy", busy, 0);
    check("abort_locked", locked, 0);
    check("abort_fail", fail, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_start_ignored", busy, 0);

    // No edges at all: descends to tap 0 and fails.
    run(4, 50, 2, 0, "m4");
    check("m4_fail_flag", fail, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
